// File: rtl/clkrst_seq.sv
`default_nettype none
// ============================================================================
// Module : clkrst_seq
// Lock-filtered reset sequencer with staged per-channel release; optional
// clock-enable dividers built when CLKRST_SEQ_CLKEN_EN is defined.
// Rev    : 1.0
// ============================================================================
module clkrst_seq #(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 8,
   parameter int LOCK_FILTER = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    pll_locked_i,
   input  logic                    ext_rst_ni,
   input  logic [NUM_CH*CNT_W-1:0] div_i,
   output logic [NUM_CH-1:0]       rst_no,
   output logic [NUM_CH-1:0]       clk_en_o,
   output logic                    ready_o,
   output logic [1:0]              state_o
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      HOLD      = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam int REL_LAST_I = STAGE_GAP * (NUM_CH - 1);
   localparam int MAX_A      = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
   localparam int SEQ_MAX    = (MAX_A > REL_LAST_I + 1) ? MAX_A : REL_LAST_I + 1;
   localparam int SEQ_W      = $clog2(SEQ_MAX + 1);

   localparam logic [SEQ_W-1:0] LOCK_LAST = SEQ_W'(LOCK_FILTER - 1);
   localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYCLES - 1);
   localparam logic [SEQ_W-1:0] REL_LAST  = SEQ_W'(REL_LAST_I);

   logic [1:0]        lock_sync_q;
   logic [1:0]        ext_sync_q;
   logic              good_s;
   state_t            state_q, state_d;
   logic [SEQ_W-1:0]  cnt_q, cnt_d;
   logic [NUM_CH-1:0] rst_n_q, rst_n_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_sync_q <= '0;
         ext_sync_q  <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[0], pll_locked_i};
         ext_sync_q  <= {ext_sync_q[0], ext_rst_ni};
      end
   end

   assign good_s = lock_sync_q[1] & ext_sync_q[1];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= WAIT_LOCK;
         cnt_q   <= '0;
         rst_n_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rst_n_q <= rst_n_d;
      end
   end

   // One shared counter: lock filter, hold time, then cycles since release began.
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      rst_n_d = '0;
      case (state_q)
         WAIT_LOCK: begin
            if (good_s) begin
               if (cnt_q == LOCK_LAST) state_d = HOLD;
               else                    cnt_d   = cnt_q + SEQ_W'(1);
            end
         end
         HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = RELEASE;
            else                    cnt_d   = cnt_q + SEQ_W'(1);
         end
         RELEASE: begin
            for (int k = 0; k < NUM_CH; k++)
               rst_n_d[k] = (cnt_q >= SEQ_W'(STAGE_GAP * k));
            if (cnt_q == REL_LAST) state_d = RUN;
            else                   cnt_d   = cnt_q + SEQ_W'(1);
         end
         RUN: begin
            rst_n_d = '1;
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase
      if ((state_q != WAIT_LOCK) && !good_s) begin
         state_d = WAIT_LOCK;
         cnt_d   = '0;
         rst_n_d = '0;
      end
   end

   assign rst_no  = rst_n_q;
   assign ready_o = (state_q == RUN);
   assign state_o = state_q;

`ifdef CLKRST_SEQ_CLKEN_EN
   for (genvar k = 0; k < NUM_CH; k++) begin : g_div
      logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
      logic [CNT_W-1:0] per_q, per_d;
      logic [CNT_W-1:0] div_k;
      logic             pulse;

      assign div_k = div_i[k*CNT_W +: CNT_W];
      assign pulse = rst_n_q[k] && (div_cnt_q == '0);

      // The period is latched only on the pulse cycle so a new div never cuts a period short.
      always_comb begin
         per_d     = '0;
         div_cnt_d = '0;
         if (pulse) begin
            per_d     = div_k;
            div_cnt_d = (div_k > CNT_W'(1)) ? CNT_W'(1) : '0;
         end else if (rst_n_q[k]) begin
            per_d     = per_q;
            div_cnt_d = (div_cnt_q == per_q - CNT_W'(1)) ? '0 : div_cnt_q + CNT_W'(1);
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            div_cnt_q <= '0;
            per_q     <= '0;
         end else begin
            div_cnt_q <= div_cnt_d;
            per_q     <= per_d;
         end
      end

      assign clk_en_o[k] = pulse;
   end
`else
   logic unused_div;
   assign unused_div = ^div_i;
   assign clk_en_o   = rst_n_q;
`endif

endmodule
`default_nettype wire
